// File: rtl/prbs_checker.sv
// Self-synchronising serial checker for the 32-bit dither LFSR sequence.
// Seeds its history from the stream, verifies a run of correct predictions, then flags and counts bit errors while locked.
module prbs_checker #(
    parameter logic [31:0] TAPS        = 32'h80200003,
    parameter int          LOCK_LEN    = 64,
    parameter int          WINDOW      = 256,
    parameter int          LOSS_THRESH = 16,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count,
    output logic             lock_lost
);

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam logic [15:0]      LOCK_LAST = 16'(LOCK_LEN - 1);
    localparam logic [15:0]      WIN_LAST  = 16'(WINDOW - 1);
    localparam logic [15:0]      LOSS_C    = 16'(LOSS_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // Next bit predicted by the recurrence: parity of the tapped history bits.
    function automatic logic predict(input logic [31:0] hist);
        return ^(hist & TAPS);
    endfunction

    state_e           state_q, state_d;
    logic [31:0]      h_q, h_d;
    logic [5:0]       fill_q, fill_d;
    logic [15:0]      match_q, match_d;
    logic [15:0]      win_cnt_q, win_cnt_d;
    logic [15:0]      win_err_q, win_err_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;
    logic             lock_lost_q, lock_lost_d;
    logic             pred_s;
    logic             mis_s;
    logic [15:0]      win_err_inc_s;

    // Next-state logic for the seed/verify/locked sequencer, window and counters.
    always_comb begin
        state_d       = state_q;
        h_d           = h_q;
        fill_d        = fill_q;
        match_d       = match_q;
        win_cnt_d     = win_cnt_q;
        win_err_d     = win_err_q;
        err_d         = 1'b0;
        err_count_d   = err_count_q;
        bit_count_d   = bit_count_q;
        lock_lost_d   = lock_lost_q;
        pred_s        = predict(h_q);
        mis_s         = in_bit ^ pred_s;
        win_err_inc_s = win_err_q + {15'd0, mis_s};

        if (in_valid) begin
            case (state_q)
                ST_SEED: begin
                    h_d = {h_q[30:0], in_bit};
                    if (fill_q == 6'd31) begin
                        state_d = ST_VERIFY;
                        fill_d  = 6'd0;
                        match_d = 16'd0;
                    end else begin
                        fill_d = fill_q + 6'd1;
                    end
                end
                ST_VERIFY: begin
                    // Keep re-seeding from the received bits; an all-zero history never counts as a match.
                    h_d = {h_q[30:0], in_bit};
                    if (!mis_s && (h_q != 32'd0)) begin
                        if (match_q == LOCK_LAST) begin
                            state_d   = ST_LOCKED;
                            match_d   = 16'd0;
                            win_cnt_d = 16'd0;
                            win_err_d = 16'd0;
                        end else begin
                            match_d = match_q + 16'd1;
                        end
                    end else begin
                        match_d = 16'd0;
                    end
                end
                ST_LOCKED: begin
                    // Shift in the prediction so a corrupted bit cannot poison later predictions.
                    h_d         = {h_q[30:0], pred_s};
                    err_d       = mis_s;
                    bit_count_d = (bit_count_q == CNT_MAX) ? bit_count_q : bit_count_q + CNT_ONE;
                    if (mis_s) begin
                        err_count_d = (err_count_q == CNT_MAX) ? err_count_q : err_count_q + CNT_ONE;
                    end else begin
                        err_count_d = err_count_q;
                    end
                    if (mis_s && (win_err_inc_s == LOSS_C)) begin
                        state_d     = ST_SEED;
                        fill_d      = 6'd0;
                        lock_lost_d = 1'b1;
                        win_cnt_d   = 16'd0;
                        win_err_d   = 16'd0;
                    end else if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d = 16'd0;
                        win_err_d = 16'd0;
                    end else begin
                        win_cnt_d = win_cnt_q + 16'd1;
                        win_err_d = win_err_inc_s;
                    end
                end
                default: begin
                    state_d = ST_SEED;
                    fill_d  = 6'd0;
                end
            endcase
        end else begin
            err_d = 1'b0;
        end

        // A clear wins over any same-cycle increment or loss flag.
        err_count_d = clr_cnt ? {CNT_W{1'b0}} : err_count_d;
        bit_count_d = clr_cnt ? {CNT_W{1'b0}} : bit_count_d;
        lock_lost_d = clr_cnt ? 1'b0 : lock_lost_d;
        locked_d    = (state_d == ST_LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SEED;
            h_q         <= 32'd0;
            fill_q      <= 6'd0;
            match_q     <= 16'd0;
            win_cnt_q   <= 16'd0;
            win_err_q   <= 16'd0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= {CNT_W{1'b0}};
            bit_count_q <= {CNT_W{1'b0}};
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            bit_count_q <= bit_count_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign locked    = locked_q;
    assign err       = err_q;
    assign err_count = err_count_q;
    assign bit_count = bit_count_q;
    assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: recurrence-based stream source plus a bit-level reference model of the checker.
module tb_prbs_checker;

    localparam logic [31:0] TAPS        = 32'h80200003;
    localparam int          LOCK_LEN    = 64;
    localparam int          WINDOW      = 256;
    localparam int          LOSS_THRESH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        locked;
    logic        err;
    logic [31:0] err_count;
    logic [31:0] bit_count;
    logic        lock_lost;

    int checks = 0;
    int errors = 0;

    prbs_checker #(
        .TAPS(TAPS), .LOCK_LEN(LOCK_LEN), .WINDOW(WINDOW),
        .LOSS_THRESH(LOSS_THRESH), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
        .locked(locked), .err(err), .err_count(err_count), .bit_count(bit_count),
        .lock_lost(lock_lost)
    );

    always #5 clk = ~clk;

    // Source stream: b[n] = b[n-1]^b[n-2]^b[n-22]^b[n-32], newest at the back.
    bit g_hist[$];

    task automatic gen_seed(input logic [31:0] s);
        g_hist = {};
        for (int i = 0; i < 32; i++) g_hist.push_back(s[i]);
    endtask

    task automatic gen_next(output bit b);
        b = g_hist[31] ^ g_hist[30] ^ g_hist[10] ^ g_hist[0];
        g_hist.push_back(b);
        void'(g_hist.pop_front());
    endtask

    // Reference model: 0=seed, 1=verify, 2=locked; m_h[0] is the newest bit.
    int     m_state, m_fill, m_match, m_wc, m_we;
    longint m_errs, m_bits;
    bit     m_lost, m_err;
    bit     m_h[$];

    task automatic model_reset();
        m_state = 0; m_fill = 0; m_match = 0; m_wc = 0; m_we = 0;
        m_errs = 0; m_bits = 0; m_lost = 0; m_err = 0;
        m_h = {};
        for (int i = 0; i < 32; i++) m_h.push_back(1'b0);
    endtask

    task automatic model_step(input bit v, input bit b, input bit c);
        bit p;
        bit zero;
        m_err = 0;
        if (v) begin
            p = 0;
            zero = 1;
            for (int k = 0; k < 32; k++) begin
                if (TAPS[k]) p ^= m_h[k];
                if (m_h[k]) zero = 0;
            end
            if (m_state == 0) begin
                m_h.push_front(b); void'(m_h.pop_back());
                m_fill++;
                if (m_fill == 32) begin m_state = 1; m_match = 0; m_fill = 0; end
            end else if (m_state == 1) begin
                m_h.push_front(b); void'(m_h.pop_back());
                if (b == p && !zero) m_match++; else m_match = 0;
                if (m_match == LOCK_LEN) begin m_state = 2; m_wc = 0; m_we = 0; m_match = 0; end
            end else begin
                m_h.push_front(p); void'(m_h.pop_back());
                m_bits++;
                m_wc++;
                if (b != p) begin m_err = 1; m_errs++; m_we++; end
                if (b != p && m_we == LOSS_THRESH) begin
                    m_state = 0; m_fill = 0; m_lost = 1;
                end else if (m_wc == WINDOW) begin
                    m_wc = 0; m_we = 0;
                end
            end
        end
        if (c) begin m_errs = 0; m_bits = 0; m_lost = 0; end
    endtask

    // One clock: drive inputs, step the model at the edge, return 1 time unit later.
    task automatic cyc(input bit v, input bit b, input bit c);
        in_valid = v; in_bit = b; clr_cnt = c;
        @(posedge clk);
        model_step(v, b, c);
        #1;
        in_valid = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #7;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b want 0", locked); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err); end
        checks++; if (err_count !== 32'd0) begin errors++; $display("FAIL reset_err_count got %0d want 0", err_count); end
        checks++; if (bit_count !== 32'd0) begin errors++; $display("FAIL reset_bit_count got %0d want 0", bit_count); end
        checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL reset_lock_lost got %0b want 0", lock_lost); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_clean_lock();
        bit b;
        gen_seed(32'h9acf46de);
        for (int i = 1; i <= 96; i++) begin
            gen_next(b);
            cyc(1'b1, b, 1'b0);
            checks++;
            if (locked !== (i == 96)) begin
                errors++; $display("FAIL lock_point sample %0d got %0b want %0b", i, locked, (i == 96));
            end
        end
        for (int i = 0; i < 1000; i++) begin
            gen_next(b);
            cyc(1'b1, b, 1'b0);
            checks++;
            if (err !== 1'b0 || locked !== 1'b1) begin
                errors++; $display("FAIL clean_run bit %0d err %0b locked %0b want 0/1", i, err, locked);
            end
        end
        checks++; if (bit_count !== 32'd1000) begin errors++; $display("FAIL clean_bit_count got %0d want 1000", bit_count); end
        checks++; if (err_count !== 32'd0) begin errors++; $display("FAIL clean_err_count got %0d want 0", err_count); end
    endtask

    task automatic test_single_error();
        bit b;
        gen_next(b);
        cyc(1'b1, ~b, 1'b0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL single_err_pulse got %0b want 1", err); end
        checks++; if (err_count !== 32'd1) begin errors++; $display("FAIL single_err_count got %0d want 1", err_count); end
        for (int i = 0; i < 500; i++) begin
            gen_next(b);
            cyc(1'b1, b, 1'b0);
            checks++;
            if (err !== 1'b0 || locked !== 1'b1) begin
                errors++; $display("FAIL single_followon bit %0d err %0b locked %0b want 0/1", i, err, locked);
            end
        end
        checks++; if (err_count !== 32'd1) begin errors++; $display("FAIL single_err_count_final got %0d want 1", err_count); end
        checks++; if (bit_count !== 32'(m_bits)) begin errors++; $display("FAIL single_bit_count got %0d want %0d", bit_count, m_bits); end
    endtask

    task automatic test_loss_relock();
        bit b;
        int n;
        cyc(1'b0, 1'b0, 1'b1);
        checks++; if (err_count !== 32'd0 || bit_count !== 32'd0) begin
            errors++; $display("FAIL clr_idle err_count %0d bit_count %0d want 0/0", err_count, bit_count);
        end
        n = 0;
        while (m_wc != 0 && n < 300) begin gen_next(b); cyc(1'b1, b, 1'b0); n++; end
        for (int e = 1; e <= 16; e++) begin
            for (int k = 0; k < 7; k++) begin gen_next(b); cyc(1'b1, b, 1'b0); end
            gen_next(b);
            cyc(1'b1, ~b, 1'b0);
            checks++;
            if (err !== 1'b1 || locked !== (e < 16) || lock_lost !== (e == 16)) begin
                errors++; $display("FAIL burst_err %0d err %0b locked %0b lost %0b want 1/%0b/%0b",
                                   e, err, locked, lock_lost, (e < 16), (e == 16));
            end
        end
        n = 0;
        while (locked !== 1'b1 && n < 200) begin
            gen_next(b); cyc(1'b1, b, 1'b0); n++;
            checks++;
            if (locked !== (m_state == 2)) begin errors++; $display("FAIL relock_model at %0d got %0b want %0b", n, locked, (m_state == 2)); end
        end
        checks++; if (n !== 96) begin errors++; $display("FAIL relock_len got %0d want 96", n); end
        cyc(1'b0, 1'b0, 1'b1);
        for (int w = 0; w < 4; w++) begin
            for (int p = 0; p < 256; p++) begin
                bit inj;
                inj = (p < 240) && (p % 16 == 15);
                gen_next(b);
                cyc(1'b1, b ^ inj, 1'b0);
                checks++;
                if (locked !== 1'b1 || err !== inj) begin
                    errors++; $display("FAIL win15 w%0d p%0d locked %0b err %0b want 1/%0b", w, p, locked, err, inj);
                end
            end
        end
        checks++; if (err_count !== 32'd60) begin errors++; $display("FAIL win15_err_count got %0d want 60", err_count); end
        checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL win15_lock_lost got %0b want 0", lock_lost); end
    endtask

    task automatic test_constant();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (locked !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL const0_locked cycles %0d want 0", bad); end
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            if (locked !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL const1_locked cycles %0d want 0", bad); end
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            if (locked !== (m_state == 2)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL random_locked cycles %0d want 0", bad); end
        checks++; if (err !== 1'b0 || err_count !== 32'd0) begin
            errors++; $display("FAIL const_err err %0b err_count %0d want 0/0", err, err_count);
        end
    endtask

    task automatic test_gaps();
        bit b;
        bit v;
        int nv;
        int cy;
        do_reset();
        gen_seed(32'h1234abcd);
        nv = 0;
        cy = 0;
        while (locked !== 1'b1 && cy < 2000) begin
            v = 1'($urandom_range(0, 1));
            if (v) begin gen_next(b); nv++; end else b = 1'($urandom_range(0, 1));
            cyc(v, b, 1'b0);
            cy++;
            checks++;
            if (err !== 1'b0 || locked !== (m_state == 2)) begin
                errors++; $display("FAIL gaps cycle %0d err %0b locked %0b want 0/%0b", cy, err, locked, (m_state == 2));
            end
        end
        checks++; if (nv !== 96) begin errors++; $display("FAIL gaps_lock_point got %0d want 96", nv); end
        for (int i = 0; i < 40; i++) begin
            v = 1'($urandom_range(0, 1));
            if (v) gen_next(b); else b = 1'($urandom_range(0, 1));
            cyc(v, b, 1'b0);
            checks++;
            if (err !== 1'b0 || bit_count !== 32'(m_bits)) begin
                errors++; $display("FAIL gaps_locked %0d err %0b bit_count %0d want 0/%0d", i, err, bit_count, m_bits);
            end
        end
        gen_next(b);
        cyc(1'b1, ~b, 1'b1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL clr_coincident_err got %0b want 1", err); end
        checks++; if (err_count !== 32'd0 || bit_count !== 32'd0) begin
            errors++; $display("FAIL clr_coincident_counts err_count %0d bit_count %0d want 0/0", err_count, bit_count);
        end
        gen_next(b);
        cyc(1'b1, ~b, 1'b0);
        checks++; if (err_count !== 32'd1 || bit_count !== 32'd1) begin
            errors++; $display("FAIL after_clr_counts err_count %0d bit_count %0d want 1/1", err_count, bit_count);
        end
    endtask

    task automatic test_async_reset();
        bit b;
        int n;
        for (int i = 0; i < 20; i++) begin gen_next(b); cyc(1'b1, b, 1'b0); end
        cyc(1'b0, 1'b0, 1'b1);
        gen_next(b);
        cyc(1'b1, ~b, 1'b0);
        checks++; if (locked !== 1'b1 || err !== 1'b1 || err_count !== 32'd1) begin
            errors++; $display("FAIL pre_rst locked %0b err %0b err_count %0d want 1/1/1", locked, err, err_count);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (locked !== 1'b0 || err !== 1'b0 || err_count !== 32'd0 || bit_count !== 32'd0 || lock_lost !== 1'b0) begin
            errors++; $display("FAIL async_rst outputs locked %0b err %0b ec %0d bc %0d lost %0b want all 0",
                               locked, err, err_count, bit_count, lock_lost);
        end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        n = 0;
        while (locked !== 1'b1 && n < 200) begin gen_next(b); cyc(1'b1, b, 1'b0); n++; end
        checks++; if (n !== 96) begin errors++; $display("FAIL async_relock_len got %0d want 96", n); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_lock();
        test_single_error();
        test_loss_relock();
        test_constant();
        test_gaps();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
